// File: rtl/l2_mem_responder_pkg.sv
// Shared types and helpers for the L2 memory responder: FSM states, line sizing,
// LFSR constants and the byte-strobe mask builder.
package l2_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int line_bits(input int offset_w);
    return 32 << offset_w;
  endfunction

  // The same four byte enables apply to every 32-bit word of the line.
  function automatic logic [31:0] strb_word_mask(input logic [3:0] wstrb);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) begin
      mask[b*8 +: 8] = {8{wstrb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/l2_mem_responder_if.sv
// L2 <-> memory line port: req/addrOK/dataOK/rdy handshake with line-wide data.
interface l2_mem_responder_if
  import l2_mem_pkg::*;
#(
  parameter int LINE_BITS = line_bits(2)
);
  logic [31:0]          addr_l2cache_mem_r;
  logic [31:0]          addr_l2cache_mem_w;
  logic [LINE_BITS-1:0] dout_l2cache_mem;
  logic                 l2cache_mem_req_r;
  logic                 l2cache_mem_req_w;
  logic                 l2cache_mem_rdy;
  logic [3:0]           l2cache_mem_wstrb;
  logic [LINE_BITS-1:0] din_mem_l2cache;
  logic                 mem_l2cache_addrOK_r;
  logic                 mem_l2cache_addrOK_w;
  logic                 mem_l2cache_dataOK;

  modport master (
    output addr_l2cache_mem_r, addr_l2cache_mem_w, dout_l2cache_mem,
           l2cache_mem_req_r, l2cache_mem_req_w, l2cache_mem_rdy, l2cache_mem_wstrb,
    input  din_mem_l2cache, mem_l2cache_addrOK_r, mem_l2cache_addrOK_w, mem_l2cache_dataOK
  );

  modport slave (
    input  addr_l2cache_mem_r, addr_l2cache_mem_w, dout_l2cache_mem,
           l2cache_mem_req_r, l2cache_mem_req_w, l2cache_mem_rdy, l2cache_mem_wstrb,
    output din_mem_l2cache, mem_l2cache_addrOK_r, mem_l2cache_addrOK_w, mem_l2cache_dataOK
  );

endinterface

// File: rtl/l2_mem_responder_lfsr.sv
// 16-bit Fibonacci LFSR used to jitter response latency; only present when
// MEM_RESP_RANDLAT_EN is defined.
`ifdef MEM_RESP_RANDLAT_EN
module mem_resp_lfsr
  import l2_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (en_i) begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign lfsr_o = lfsr_q;

endmodule
`endif

// File: rtl/l2_mem_responder.sv
// Memory-side responder for the L2 miss/writeback port: line-wide backing store,
// one outstanding transaction, configurable latency. MEM_RESP_RANDLAT_EN adds 0..7 random cycles.
module l2_mem_responder
  import l2_mem_pkg::*;
#(
  parameter int OFFSET_W  = 2,
  parameter int DEPTH_W   = 10,
  parameter int LATENCY   = 4,
  parameter     INIT_FILE = ""
) (
  input logic               clk,
  input logic               rst,
  l2_mem_responder_if.slave mem_if
);

  localparam int          LINE_BITS = line_bits(OFFSET_W);
  localparam int          IDX_LSB   = OFFSET_W + 2;
  localparam logic [8:0]  BASE_LAT  = 9'(LATENCY);

  logic [LINE_BITS-1:0] mem_q [0:(1<<DEPTH_W)-1];

  resp_state_e          state_q;
  logic [8:0]           cnt_q;
  logic                 is_wr_q;
  logic [DEPTH_W-1:0]   idx_q;
  logic                 dataok_q;
  logic [LINE_BITS-1:0] din_q;

  logic [DEPTH_W-1:0]   rd_idx_s;
  logic [DEPTH_W-1:0]   wr_idx_s;
  logic                 hs_w_s;
  logic                 hs_r_s;
  logic [LINE_BITS-1:0] line_mask_s;
  logic [8:0]           lat_s;
  logic                 unused_addr_s;

  assign rd_idx_s    = mem_if.addr_l2cache_mem_r[IDX_LSB +: DEPTH_W];
  assign wr_idx_s    = mem_if.addr_l2cache_mem_w[IDX_LSB +: DEPTH_W];
  assign line_mask_s = {(LINE_BITS/32){strb_word_mask(mem_if.l2cache_mem_wstrb)}};
  assign unused_addr_s = ^{mem_if.addr_l2cache_mem_r[31:IDX_LSB+DEPTH_W],
                           mem_if.addr_l2cache_mem_r[IDX_LSB-1:0],
                           mem_if.addr_l2cache_mem_w[31:IDX_LSB+DEPTH_W],
                           mem_if.addr_l2cache_mem_w[IDX_LSB-1:0]};

  // Write beats read so a victim writeback lands before its refill is served.
  assign hs_w_s = (state_q == IDLE) & mem_if.l2cache_mem_req_w;
  assign hs_r_s = (state_q == IDLE) & mem_if.l2cache_mem_req_r & ~mem_if.l2cache_mem_req_w;

`ifdef MEM_RESP_RANDLAT_EN
  logic [15:0] lfsr_s;
  logic        unused_lfsr_s;

  mem_resp_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (1'b1),
    .lfsr_o (lfsr_s)
  );

  assign lat_s         = BASE_LAT + {6'd0, lfsr_s[2:0]};
  assign unused_lfsr_s = ^lfsr_s[15:3];
`else
  assign lat_s = BASE_LAT;
`endif

  // Array has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (hs_w_s) begin
      mem_q[wr_idx_s] <= (mem_q[wr_idx_s] & ~line_mask_s)
                       | (mem_if.dout_l2cache_mem & line_mask_s);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 9'd0;
      is_wr_q  <= 1'b0;
      idx_q    <= '0;
      dataok_q <= 1'b0;
      din_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs_w_s || hs_r_s) begin
            is_wr_q <= hs_w_s;
            idx_q   <= rd_idx_s;
            cnt_q   <= lat_s;
            if (lat_s == 9'd0) begin
              state_q  <= RESP;
              dataok_q <= 1'b1;
              if (hs_r_s) begin
                din_q <= mem_q[rd_idx_s];
              end
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q <= 9'd1) begin
            state_q  <= RESP;
            dataok_q <= 1'b1;
            cnt_q    <= 9'd0;
            if (!is_wr_q) begin
              din_q <= mem_q[idx_q];
            end
          end else begin
            cnt_q <= cnt_q - 9'd1;
          end
        end
        RESP: begin
          if (mem_if.l2cache_mem_rdy) begin
            state_q  <= IDLE;
            dataok_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          dataok_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_if.mem_l2cache_addrOK_w = hs_w_s;
  assign mem_if.mem_l2cache_addrOK_r = hs_r_s;
  assign mem_if.mem_l2cache_dataOK   = dataok_q;
  assign mem_if.din_mem_l2cache      = din_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder: LATENCY=4 instance plus a LATENCY=0 instance for aliasing.
module tb_l2_mem_responder;
  import l2_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  l2_mem_responder_if #(.LINE_BITS(128)) bus_a ();
  l2_mem_responder_if #(.LINE_BITS(128)) bus_b ();

  l2_mem_responder #(.OFFSET_W(2), .DEPTH_W(10), .LATENCY(4)) dut_a (
    .clk(clk), .rst(rst), .mem_if(bus_a));
  l2_mem_responder #(.OFFSET_W(2), .DEPTH_W(10), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .mem_if(bus_b));

  int total = 0;
  int passed = 0;
  logic [127:0] exp_q[$];
  logic [127:0] model[logic [10:0]];
  logic [127:0] last_rd[2];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input bit b, input logic rr, input logic rw, input logic [31:0] ar,
                       input logic [31:0] aw, input logic [127:0] d, input logic [3:0] s);
    if (b) begin
      bus_b.l2cache_mem_req_r = rr; bus_b.l2cache_mem_req_w = rw;
      bus_b.addr_l2cache_mem_r = ar; bus_b.addr_l2cache_mem_w = aw;
      bus_b.dout_l2cache_mem = d; bus_b.l2cache_mem_wstrb = s;
    end else begin
      bus_a.l2cache_mem_req_r = rr; bus_a.l2cache_mem_req_w = rw;
      bus_a.addr_l2cache_mem_r = ar; bus_a.addr_l2cache_mem_w = aw;
      bus_a.dout_l2cache_mem = d; bus_a.l2cache_mem_wstrb = s;
    end
  endtask

  task automatic set_rdy(input bit b, input logic v);
    if (b) bus_b.l2cache_mem_rdy = v;
    else   bus_a.l2cache_mem_rdy = v;
  endtask

  function automatic logic dok(input bit b);
    return b ? bus_b.mem_l2cache_dataOK : bus_a.mem_l2cache_dataOK;
  endfunction
  function automatic logic [127:0] din(input bit b);
    return b ? bus_b.din_mem_l2cache : bus_a.din_mem_l2cache;
  endfunction
  function automatic logic aok_r(input bit b);
    return b ? bus_b.mem_l2cache_addrOK_r : bus_a.mem_l2cache_addrOK_r;
  endfunction
  function automatic logic aok_w(input bit b);
    return b ? bus_b.mem_l2cache_addrOK_w : bus_a.mem_l2cache_addrOK_w;
  endfunction

  function automatic logic [10:0] key(input bit b, input logic [31:0] a);
    return {b, a[13:4]};
  endfunction

  task automatic model_write(input bit b, input logic [31:0] a, input logic [127:0] d,
                             input logic [3:0] s);
    logic [127:0] m;
    logic [127:0] old;
    m = 128'h0;
    for (int w = 0; w < 4; w++)
      for (int by = 0; by < 4; by++)
        m[w*32 + by*8 +: 8] = {8{s[by]}};
    old = model.exists(key(b, a)) ? model[key(b, a)] : 128'h0;
    model[key(b, a)] = (old & ~m) | (d & m);
    exp_q.push_back(last_rd[b]);
  endtask

  task automatic model_read(input bit b, input logic [31:0] a);
    last_rd[b] = model[key(b, a)];
    exp_q.push_back(last_rd[b]);
  endtask

  // Called right after the handshake edge; returns at the first negedge with dataOK.
  task automatic wait_resp(input bit b, input int exp_lat, input string tag);
    int n;
    logic [127:0] e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dok(b) && n < 300);
    check({tag, "_lat"}, 128'(n), 128'(exp_lat + 1));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    check({tag, "_din"}, din(b), e);
  endtask

  task automatic txn(input bit b, input bit is_w, input logic [31:0] addr,
                     input logic [127:0] data, input logic [3:0] strb, input int hold,
                     input int exp_lat, input string tag);
    logic [127:0] held;
    @(negedge clk);
    if (is_w) begin
      drive(b, 1'b0, 1'b1, 32'h0, addr, data, strb);
      model_write(b, addr, data, strb);
    end else begin
      drive(b, 1'b1, 1'b0, addr, 32'h0, 128'h0, 4'h0);
      model_read(b, addr);
    end
    #1;
    check({tag, "_aok"}, 128'(is_w ? aok_w(b) : aok_r(b)), 128'd1);
    @(posedge clk);
    #1;
    drive(b, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0, 4'h0);
    wait_resp(b, exp_lat, tag);
    if (hold > 0) begin
      set_rdy(b, 1'b0);
      held = din(b);
      for (int i = 0; i < hold; i++) begin
        drive(b, 1'b1, 1'b0, addr, 32'h0, 128'h0, 4'h0);
        @(negedge clk);
        check({tag, "_hold_dok"}, 128'(dok(b)), 128'd1);
        check({tag, "_hold_din"}, din(b), held);
        check({tag, "_hold_aok"}, 128'(aok_r(b)), 128'd0);
      end
      drive(b, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0, 4'h0);
      set_rdy(b, 1'b1);
    end
    @(posedge clk);
    #1;
    check({tag, "_done"}, 128'(dok(b)), 128'd0);
  endtask

  initial begin
    logic [127:0] d1, d3, d6, d7;
    d1 = {32'd4, 32'd3, 32'd2, 32'd1};
    d3 = 128'hA5A5_0003_1234_5678_0BAD_F00D_CAFE_0300;
    d6 = 128'h6666_0006_5555_1111_2222_3333_4444_0600;
    d7 = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_4000;
    last_rd[0] = 128'h0;
    last_rd[1] = 128'h0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0, 4'h0);
    set_rdy(1'b0, 1'b1);
    set_rdy(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("rst_dok", 128'(dok(1'b0)), 128'd0);
    check("rst_din", din(1'b0), 128'h0);
    check("rst_aok_w", 128'(aok_w(1'b0)), 128'd0);
    rst = 1'b0;

    // Full write then read.
    txn(1'b0, 1'b1, 32'h100, d1, 4'hF, 0, 4, "wr100");
    txn(1'b0, 1'b0, 32'h100, 128'h0, 4'h0, 0, 4, "rd100");
    check("rd100_const", din(1'b0), 128'h00000004_00000003_00000002_00000001);

    // Byte strobes, and a zero-strobe write that must leave the line alone.
    txn(1'b0, 1'b1, 32'h200, {128{1'b1}}, 4'hF, 0, 4, "wr200_ff");
    txn(1'b0, 1'b1, 32'h200, {4{32'h11223344}}, 4'b0101, 0, 4, "wr200_strb");
    txn(1'b0, 1'b0, 32'h200, 128'h0, 4'h0, 0, 4, "rd200");
    check("rd200_const", din(1'b0), {4{32'hFF22FF44}});
    txn(1'b0, 1'b1, 32'h100, {4{32'hDEADBEEF}}, 4'h0, 0, 4, "wr100_nostrb");
    txn(1'b0, 1'b0, 32'h100, 128'h0, 4'h0, 0, 4, "rd100_again");

    // Simultaneous read and write to 0x300: write first.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h300, 32'h300, d3, 4'hF);
    model_write(1'b0, 32'h300, d3, 4'hF);
    #1;
    check("sim_aok_w", 128'(aok_w(1'b0)), 128'd1);
    check("sim_aok_r", 128'(aok_r(1'b0)), 128'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 128'h0, 4'h0);
    wait_resp(1'b0, 4, "sim_wr");
    check("sim_aok_r_busy", 128'(aok_r(1'b0)), 128'd0);
    @(posedge clk);
    #1;
    check("sim_aok_r_after", 128'(aok_r(1'b0)), 128'd1);
    model_read(1'b0, 32'h300);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0, 4'h0);
    wait_resp(1'b0, 4, "sim_rd");
    @(posedge clk);
    #1;

    // Backpressure on a read response.
    txn(1'b0, 1'b0, 32'h300, 128'h0, 4'h0, 6, 4, "bp");

    // Reset while a write is in WAIT; its data must already be committed.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h600, d6, 4'hF);
    model_write(1'b0, 32'h600, d6, 4'hF);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_dok", 128'(dok(1'b0)), 128'd0);
    check("mid_rst_din", din(1'b0), 128'h0);
    last_rd[0] = 128'h0;
    last_rd[1] = 128'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_dok", 128'(dok(1'b0)), 128'd0);
    txn(1'b0, 1'b0, 32'h600, 128'h0, 4'h0, 0, 4, "rd600");

    // LATENCY=0 instance: 0x4000 aliases line 0.
    txn(1'b1, 1'b1, 32'h4000, d7, 4'hF, 0, 0, "b_wr4000");
    txn(1'b1, 1'b0, 32'h0, 128'h0, 4'h0, 0, 0, "b_rd0");
    check("b_rd0_const", din(1'b1), d7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
